// File: rtl/uart_transmitter_if.sv
//==============================================================================
// uart_transmitter_if: byte valid/ready handshake into the UART transmitter.
//==============================================================================
`default_nettype none

interface uart_transmitter_if;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       data_ready_o;

  modport master (
    output data_i,
    output data_valid_i,
    input  data_ready_o
  );

  modport slave (
    input  data_i,
    input  data_valid_i,
    output data_ready_o
  );
endinterface

`default_nettype wire

// File: rtl/uart_transmitter.sv
//==============================================================================
// uart_transmitter: FIFO-buffered 8N1 serialiser, LSB first.  Rev 1.0
//==============================================================================
`default_nettype none

module uart_transmitter #(
  parameter int CLK_FREQ     = 1_000_000_000,
  parameter int BAUD_RATE    = 100_000_000,
  parameter int CLK_PER_BAUD = CLK_FREQ / BAUD_RATE,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  uart_transmitter_if.slave   byte_if,
  output logic                tx_o,
  output logic                busy_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BAUD - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [7:0]        shift_reg;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic baud_last;

  assign full      = (fifo_cnt == FIFO_FULL);
  assign empty     = (fifo_cnt == '0);
  assign baud_last = (baud_cnt == BAUD_LAST);
  // Pushes are gated by full alone, so a pop on a full FIFO never admits a push.
  assign push      = byte_if.data_valid_i && !full;
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_last));

  assign byte_if.data_ready_o = !full;
  assign busy_o               = (state != IDLE) || !empty;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= byte_if.data_i;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= IDLE;
      tx_o      <= 1'b1;
      shift_reg <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            tx_o      <= 1'b0;
            baud_cnt  <= '0;
            state     <= START;
          end
        end

        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx_o     <= shift_reg[0];
            bit_cnt  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              tx_o      <= shift_reg[1];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when a byte is waiting.
            if (pop) begin
              shift_reg <= fifo_mem[rd_ptr];
              tx_o      <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
//==============================================================================
// tb_uart_transmitter: random pushes, scoreboard queue, line-level frame monitor.
//==============================================================================
`default_nettype none

module tb_uart_transmitter;

  localparam int CPB_A = 10;
  localparam int CPB_B = 3;

  logic clk = 1'b0;
  logic arstn;
  logic tx_a, busy_a, tx_b, busy_b;

  always #5 clk = ~clk;

  uart_transmitter_if if_a ();
  uart_transmitter_if if_b ();

  uart_transmitter #(
    .CLK_FREQ(1_000_000_000), .BAUD_RATE(100_000_000),
    .CLK_PER_BAUD(CPB_A), .FIFO_DEPTH(4)
  ) dut_a (
    .clk_i(clk), .arstn_i(arstn), .byte_if(if_a), .tx_o(tx_a), .busy_o(busy_a)
  );

  uart_transmitter #(
    .CLK_FREQ(300), .BAUD_RATE(100),
    .CLK_PER_BAUD(CPB_B), .FIFO_DEPTH(2)
  ) dut_b (
    .clk_i(clk), .arstn_i(arstn), .byte_if(if_b), .tx_o(tx_b), .busy_o(busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: bytes in acceptance order; the monitor pops one per observed frame.
  logic [7:0] exp_q[$];
  int         acc_cnt = 0;
  int         started = 0;

  bit         in_frame = 0;
  bit         gap_pend = 0;
  bit         gap_start = 0;
  int         idx, wave_err, bitpos;
  logic [7:0] cur_exp, dec;
  logic       lvl;

  always @(negedge clk) begin
    if (!arstn) begin
      in_frame = 0;
      gap_pend = 0;
      started  = 0;
    end else begin
      if (gap_pend) begin
        chk("b2b_gap", tx_a, gap_start ? 1'b0 : 1'b1);
        gap_pend = 0;
      end
      if (!in_frame && tx_a == 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          cur_exp = 8'h00;
        end else begin
          cur_exp = exp_q.pop_front();
        end
        started++;
        in_frame = 1;
        idx      = 0;
        wave_err = 0;
        dec      = 8'h00;
      end
      if (in_frame) begin
        bitpos = idx / CPB_A;
        if (bitpos == 0)      lvl = 1'b0;
        else if (bitpos == 9) lvl = 1'b1;
        else                  lvl = cur_exp[bitpos-1];
        if (tx_a !== lvl) wave_err++;
        if ((idx % CPB_A) == CPB_A / 2 && bitpos >= 1 && bitpos <= 8) dec[bitpos-1] = tx_a;
        if (idx == 10 * CPB_A - 1) begin
          chk("frame_wave", wave_err, 0);
          chk("frame_byte", dec, cur_exp);
          in_frame  = 0;
          gap_pend  = 1;
          gap_start = (acc_cnt > started);
        end
        idx++;
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic push_a(input logic [7:0] b, input int max_wait);
    int  w = 0;
    bit  done = 0;
    if_a.data_i       = b;
    if_a.data_valid_i = 1'b1;
    while (!done) begin
      #1;
      if (if_a.data_ready_o) begin
        exp_q.push_back(b);
        acc_cnt++;
        done = 1;
      end else if (w >= max_wait) begin
        chk("push_timeout", 0, 1);
        done = 1;
      end
      @(negedge clk);
      w++;
    end
    if_a.data_valid_i = 1'b0;
  endtask

  task automatic drain_a(input int max_cycles);
    int  w = 0;
    bit  ok = 0;
    while (!ok && w < max_cycles) begin
      @(negedge clk);
      #2;
      ok = !busy_a && !in_frame && exp_q.size() == 0;
      w++;
    end
    chk("drain", ok, 1);
    @(negedge clk);
  endtask

  logic [7:0] d;
  logic       wave_b [64];
  int         acc, acc2, errs, f;
  bit         stopped;

  initial begin
    arstn             = 1'b0;
    if_a.data_i       = 8'h00;
    if_a.data_valid_i = 1'b0;
    if_b.data_i       = 8'h00;
    if_b.data_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_ready", if_a.data_ready_o, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_tx_b", tx_b, 1);
    arstn = 1'b1;
    @(negedge clk);

    // Single 0xA5: line falls one cycle after the handshake edge.
    push_a(8'hA5, 10);
    chk("lat_pre_tx", tx_a, 1);
    chk("lat_pre_busy", busy_a, 1);
    @(negedge clk);
    chk("lat_fall", tx_a, 0);
    drain_a(300);
    chk("busy_after_stop", busy_a, 0);

    push_a(8'h00, 10);
    push_a(8'hFF, 10);
    drain_a(400);

    // Held valid with incrementing data: 4 in FIFO + 1 in shift register.
    acc = 0;
    d   = 8'h40;
    if_a.data_valid_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if_a.data_i = d;
      #1;
      if (if_a.data_ready_o) begin
        exp_q.push_back(d);
        acc_cnt++;
        acc++;
        d++;
        @(negedge clk);
      end else begin
        break;
      end
    end
    chk("cap_accepts", acc, 5);
    chk("cap_ready_low", if_a.data_ready_o, 0);
    acc2 = 0;
    repeat (250) begin
      @(negedge clk);
      if_a.data_i = d;
      #1;
      if (if_a.data_ready_o) begin
        exp_q.push_back(d);
        acc_cnt++;
        acc2++;
        d++;
      end
    end
    @(negedge clk);
    if_a.data_valid_i = 1'b0;
    chk("cap_one_per_frame", acc2, 2);
    drain_a(1000);

    // Reset in the middle of 0x3C's data bits with two bytes still queued.
    push_a(8'h3C, 10);
    push_a(8'h11, 10);
    push_a(8'h22, 10);
    repeat (40) @(negedge clk);
    #3;
    arstn = 1'b0;
    #1;
    chk("mid_rst_tx", tx_a, 1);
    chk("mid_rst_ready", if_a.data_ready_o, 1);
    chk("mid_rst_busy", busy_a, 0);
    exp_q.delete();
    acc_cnt = 0;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    errs = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) errs++;
    end
    chk("idle_after_rst", errs, 0);

    // Random bytes with random inter-push gaps.
    for (int i = 0; i < 32; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_a(8'($urandom), 300);
    end
    drain_a(4000);

    // Non-default instance: 3 cycles per bit, 2-entry FIFO.
    acc     = 0;
    stopped = 0;
    d       = 8'h81;
    if_b.data_valid_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      wave_b[c]   = tx_b;
      if_b.data_i = d;
      #1;
      if (!stopped) begin
        if (if_b.data_ready_o) begin
          acc++;
          d++;
        end else begin
          stopped = 1;
          if_b.data_valid_i = 1'b0;
        end
      end
      @(negedge clk);
    end
    if_b.data_valid_i = 1'b0;
    chk("b_accepts", acc, 3);
    f = -1;
    for (int c = 0; c < 60; c++) begin
      if (f < 0 && wave_b[c] == 1'b0) f = c;
    end
    chk("b_latency", f, 2);
    if (f < 0) f = 0;
    errs = 0;
    d    = 8'h81;
    for (int k = 0; k < 10 * CPB_B; k++) begin
      bitpos = k / CPB_B;
      if (bitpos == 0)      lvl = 1'b0;
      else if (bitpos == 9) lvl = 1'b1;
      else                  lvl = d[bitpos-1];
      if (wave_b[f + k] !== lvl) errs++;
    end
    chk("b_wave", errs, 0);
    chk("b_b2b_start", wave_b[f + 10 * CPB_B], 0);
    repeat (60) @(negedge clk);
    chk("b_idle_busy", busy_b, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/uart_transmitter.md
# uart_transmitter

UART transmit side of the debug/host link. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each byte onto `tx_o` as a standard 8N1 frame: one start bit, eight data bits LSB first, one stop bit, no parity. It pairs with the existing UART receiver and shares its clock, reset and baud parameters, so a `tx_o`→`rx_i` loopback works without retuning.

## Interface
- `CLK_FREQ`, 1_000_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 100_000_000: line rate in bits/s.
- `CLK_PER_BAUD`, `CLK_FREQ / BAUD_RATE`: clock cycles per bit. Must be ≥ 2.
- `FIFO_DEPTH`, 4: number of input FIFO entries. Power of two, ≥ 2.
- `clk_i` input 1: system clock. Everything is rising-edge triggered.
- `arstn_i` input 1: reset, asynchronous, active-low.
- `data_i` input 8: byte to send. Sampled only on a handshake.
- `data_valid_i` input 1: `data_i` is valid.
- `data_ready_o` output 1: FIFO can accept a byte.
- `tx_o` output 1: serial line, idle high, driven from a register.
- `busy_o` output 1: a frame is in progress or the FIFO is not empty.

## Operation
- Handshake: a byte transfers on a rising edge where `data_valid_i && data_ready_o`. The byte is pushed into the FIFO.
- `data_ready_o` is `!full`, derived from the FIFO count.
- A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- If a push and a pop happen in the same cycle with the FIFO not full, both take effect and the count is unchanged.
- FIFO: circular buffer with read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap naturally, plus a count of `$clog2(FIFO_DEPTH)+1` bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx_o`=1. If the FIFO is not empty: pop the byte into the 8-bit shift register, set `tx_o`←0, clear the baud counter, go to START.
  - START: hold for `CLK_PER_BAUD` cycles. Then drive `tx_o`←shift[0], clear the bit counter, go to DATA.
  - DATA: each bit is held `CLK_PER_BAUD` cycles, then the register shifts right and `tx_o` takes the next bit. After bit 7 (bit counter == 7) completes, drive `tx_o`←1 and go to STOP.
  - STOP: hold for `CLK_PER_BAUD` cycles. At the end, if the FIFO is not empty, pop the next byte, drive `tx_o`←0 and go to START with no idle gap. Otherwise go to IDLE.
- Baud counter: `$clog2(CLK_PER_BAUD)` bits, counts 0..`CLK_PER_BAUD`-1 and wraps at the end of each bit. Bit counter: 3 bits.
- `busy_o` = (state != IDLE) || (count != 0).
- Reset, including mid-frame: aborts the frame immediately. `tx_o`=1, FSM=IDLE, FIFO flushed (pointers and count = 0), `data_ready_o`=1, `busy_o`=0. The shift register and counters reset to 0.

## Timing
- Accept latency: byte accepted at edge N into an empty FIFO while in IDLE → `tx_o` falls after edge N+1.
- Frame length: exactly 10×`CLK_PER_BAUD` cycles, which is 100 cycles at the defaults. Each bit lasts exactly `CLK_PER_BAUD` cycles with no jitter.
- Back-to-back frames: the next start bit begins on the cycle after the last stop-bit cycle.
- Capacity: `FIFO_DEPTH` bytes in the FIFO plus 1 in the shift register. `data_ready_o` returns high the cycle after the pop that relieves full.
- `data_valid_i` may be held high indefinitely. Each accepting edge consumes exactly one byte.
- `tx_o` has no combinational path from any input.

## Test plan
- Single byte 0xA5 after reset, idle line → `tx_o` levels per 10-cycle bit: 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop). Falling edge occurs 1 cycle after the handshake. `busy_o` deasserts after the stop bit.
- Push 0x00 then 0xFF back-to-back → two contiguous 100-cycle frames with no idle gap between stop and start. Second frame: 0, eight 1s, 1.
- Hold `data_valid_i`=1 with incrementing data at defaults → 5 bytes accepted (4 in FIFO, 1 in the shift register), then `data_ready_o`=0. Exactly one further acceptance occurs per frame. Sent sequence matches the push order.
- Assert `arstn_i` low mid-DATA of 0x3C with 2 bytes queued → `tx_o`=1 immediately, FIFO empty, `data_ready_o`=1, `busy_o`=0. After release the line stays idle until a new push.
- `tx_o` looped to the receiver's `rx_i`, 32 random bytes → the receiver outputs the identical byte sequence. No framing gaps or losses.
- Non-default parameters `CLK_PER_BAUD`=3, `FIFO_DEPTH`=2, byte 0x81 → every bit lasts exactly 3 cycles. Acceptance stalls after 3 bytes.
